rx_frame_controller: RTL
========================

// Module: rx_frame_controller
// PURPOSE
//  Sequences the zero-crossing demodulator datapath: times 32-clock bit windows and samples/clears the zero-crossing count.
//  Decides each bit and assembles 16-bit frames into DATA_BYTE_1/DATA_BYTE_0.
//  Owns the RX status/interrupt bits seen by the host through BD_CONTROL.
//  Sits between the zero-crossing counter and the host register interface.
// PARAMETERS
//  CLKS_PER_BIT  32     clocks per bit window (>=4)
//  ZC_THRESH     0      bit=1 if zc_count<=ZC_THRESH, else bit=0
//  SYNC_WORD     8'hA5  sync pattern hunted when RX_SYNC_EN defined
// PORTS
//  G_CLK_RX     in   1  receive clock
//  reset        in   1  asynchronous, active-high
//  rx_enable    in   1  BD_CONTROL[0] RXENABLE, level
//  int_mask     in   1  BD_CONTROL[1] INTMASK, 1=interrupt enabled
//  int_clear    in   1  host write-1-to-clear pulse for int_flag/overrun
//  zc_count     in   8  zero crossings counted in current window
//  zc_clear     out  1  1-cycle pulse, counter clears on next edge
//  bit_strobe   out  1  1-cycle pulse when a bit is decided
//  DATA_BYTE_1  out  8  first 8 received bits, MSB first
//  DATA_BYTE_0  out  8  last 8 received bits, MSB first
//  status       out  1  BD_CONTROL[3] STATUS, 1 while in RECV
//  int_flag     out  1  BD_CONTROL[2] INTFLAG, frame-complete sticky flag
//  overrun      out  1  sticky: frame completed while int_flag already set
//  int_rx_host  out  1  int_flag & int_mask, registered
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, clk_cnt=0, bit_cnt=0, shift reg=0.
//  FSM states:
//   IDLE: leaves on rx_enable=1, to HUNT (macro on) or RECV (macro off).
//     The entry cycle pulses zc_clear and loads clk_cnt=0.
//   HUNT and RECV: rx_enable=0 in any cycle -> IDLE next edge.
//     Partial frame discarded; DATA_BYTE_* unchanged; no flag change.
//  Window: clk_cnt counts 0..CLKS_PER_BIT-1 and wraps.
//   At clk_cnt==CLKS_PER_BIT-1: sample zc_count, decide bit, pulse bit_strobe and zc_clear in the same cycle.
//  RECV: each bit shifts into a 16-bit shift reg; bit_cnt counts 0..15.
//   On the 16th bit: register both bytes atomically (first bit -> DATA_BYTE_1[7], last -> DATA_BYTE_0[0]).
//   Also set int_flag, clear bit_cnt. Next state: RECV (macro off) or HUNT (macro on).
//   DATA_BYTE_* never change mid-frame.
//  Flags:
//   Frame done with int_flag=1 -> overrun=1; bytes still overwritten.
//   int_clear clears int_flag and overrun next edge.
//   A set in the same cycle as int_clear wins (flag stays 1; overrun not set).
//  int_rx_host follows int_flag&int_mask one clock later; a mask change never alters int_flag.
//  No bit decision is possible before CLKS_PER_BIT clocks after leaving IDLE.
// CONFIGURATION
//  RX_SYNC_EN defined:
//   HUNT shifts decided bits into an 8-bit window; when it equals SYNC_WORD -> RECV, bit_cnt=0.
//   Sync bits are not stored; status=0 in HUNT.
//  RX_SYNC_EN undefined: no HUNT state; IDLE->RECV directly; frames run back-to-back.
// TESTING
//  Reset mid-RECV -> all outputs 0 within same cycle, IDLE.
//  Macro off, rx_enable=1, zc_count=0 for 16 windows -> bytes 8'hFF/8'hFF, int_flag=1 after 512 clocks.
//  Alternate zc_count 0/5 per window, int_mask=1 -> bytes 8'hAA/8'hAA, int_rx_host=1 one clock after int_flag.
//  Second frame without int_clear -> overrun=1, bytes updated; int_clear -> both 0.
//  int_clear coincident with frame done -> int_flag=1, overrun=0.
//  rx_enable=0 after bit 9 -> IDLE, bytes keep prior frame, int_flag unchanged.
//  Macro on: bits A5 then 16'h1234 -> DATA_BYTE_1=8'h12, DATA_BYTE_0=8'h34.

Source files
------------

// File: rtl/rx_frame_controller.sv
// rx_frame_controller: sequences the zero-crossing demodulator. Times bit
// windows, samples and clears the zero-crossing counter, decides each bit,
// assembles 16-bit frames into DATA_BYTE_1/DATA_BYTE_0 and owns the RX
// status/interrupt bits exposed through BD_CONTROL.
// Optional feature: define RX_SYNC_EN to hunt for SYNC_WORD before every
// frame (SYNC_WORD exists only in that build). Without it, frames run
// back-to-back from the moment rx_enable rises.
module rx_frame_controller #(
   parameter int CLKS_PER_BIT = 32,
   parameter int ZC_THRESH    = 0
`ifdef RX_SYNC_EN
   ,
   parameter logic [7:0] SYNC_WORD = 8'hA5
`endif
) (
   input  logic       G_CLK_RX,
   input  logic       reset,
   input  logic       rx_enable,
   input  logic       int_mask,
   input  logic       int_clear,
   input  logic [7:0] zc_count,
   output logic       zc_clear,
   output logic       bit_strobe,
   output logic [7:0] DATA_BYTE_1,
   output logic [7:0] DATA_BYTE_0,
   output logic       status,
   output logic       int_flag,
   output logic       overrun,
   output logic       int_rx_host
);

   localparam int              CW     = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [7:0]      THRESH = 8'(ZC_THRESH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUNT = 2'd1,
      RECV = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] clk_cnt;
   logic [3:0]    bit_cnt;
   logic [14:0]   shift_reg;
`ifdef RX_SYNC_EN
   logic [7:0]    sync_win;
`endif

   logic          window_end;
   logic          bit_value;
   logic          frame_done;
   logic [15:0]   shift_next;

   // Window-end decode and bit decision; strobes come straight from registered counters
   always_comb begin
      window_end = (state != IDLE) && (clk_cnt == LAST);
      bit_value  = (zc_count <= THRESH);
      shift_next = {shift_reg, bit_value};
      frame_done = (state == RECV) && rx_enable && window_end && (bit_cnt == 4'd15);
      bit_strobe = window_end;
      zc_clear   = window_end || ((state == IDLE) && rx_enable && !reset);
      status     = (state == RECV);
   end

   // Sequencer: window timing, bit counting, frame assembly and sync hunting
   always_ff @(posedge G_CLK_RX or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
`ifdef RX_SYNC_EN
         sync_win  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (rx_enable) begin
`ifdef RX_SYNC_EN
                  state <= HUNT;
`else
                  state <= RECV;
`endif
                  clk_cnt   <= '0;
                  bit_cnt   <= '0;
                  shift_reg <= '0;
`ifdef RX_SYNC_EN
                  sync_win  <= '0;
`endif
               end
            end
            default: begin
               if (!rx_enable) begin
                  state     <= IDLE;
                  clk_cnt   <= '0;
                  bit_cnt   <= '0;
                  shift_reg <= '0;
`ifdef RX_SYNC_EN
                  sync_win  <= '0;
`endif
               end else begin
                  clk_cnt <= window_end ? '0 : clk_cnt + 1'b1;
                  if (window_end && (state == RECV)) begin
                     shift_reg <= shift_next[14:0];
                     if (bit_cnt == 4'd15) begin
                        bit_cnt <= '0;
`ifdef RX_SYNC_EN
                        state    <= HUNT;
                        sync_win <= '0;
`endif
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
`ifdef RX_SYNC_EN
                  else if (window_end && (state == HUNT)) begin
                     sync_win <= {sync_win[6:0], bit_value};
                     if ({sync_win[6:0], bit_value} == SYNC_WORD) begin
                        state     <= RECV;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                     end
                  end
`endif
               end
            end
         endcase
      end
   end

   // Both data bytes update together only when a frame completes
   always_ff @(posedge G_CLK_RX or posedge reset) begin
      if (reset) begin
         DATA_BYTE_1 <= '0;
         DATA_BYTE_0 <= '0;
      end else if (frame_done) begin
         DATA_BYTE_1 <= shift_next[15:8];
         DATA_BYTE_0 <= shift_next[7:0];
      end
   end

   // Sticky frame-complete and overrun flags; a new frame beats a coincident clear
   always_ff @(posedge G_CLK_RX or posedge reset) begin
      if (reset) begin
         int_flag <= 1'b0;
         overrun  <= 1'b0;
      end else if (frame_done) begin
         int_flag <= 1'b1;
         if (int_clear)
            overrun <= 1'b0;
         else if (int_flag)
            overrun <= 1'b1;
      end else if (int_clear) begin
         int_flag <= 1'b0;
         overrun  <= 1'b0;
      end
   end

   // Host interrupt line follows the masked flag one clock later
   always_ff @(posedge G_CLK_RX or posedge reset) begin
      if (reset)
         int_rx_host <= 1'b0;
      else
         int_rx_host <= int_flag & int_mask;
   end

endmodule
